// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and state encoding for the bit-serial adder/subtractor
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder cell reused every serial step
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of one bit position
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract with start/busy/done handshake and flags
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State and datapath registers; reset clears everything including results
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sequencing: accept in IDLE/DONE, one bit per cycle in RUN, publish on the MSB step
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, so the incoming cin is ignored
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                part_d  = {fa_s, part_q[WIDTH-1:1]};
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_PRE) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == CNT_LAST) begin
                    s_d     = {fa_s, part_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = cmsb_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - randomized self-checking bench for serial_addsub at WIDTH 8 and 4
module tb_serial_addsub;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] s4;

    int n_tests = 0;
    int n_fail  = 0;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .s     (s4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    // Reference: plain integer arithmetic, signed overflow from the exact signed result
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, input logic cv,
                                  output logic [31:0] es, output logic ec, output logic eo);
        longint mask, ua, ub, u, half, sa, sb, sr;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        if (sv) u = ua + ((~ub) & mask) + 1;
        else    u = ua + ub + longint'(cv);
        es   = 32'(u & mask);
        ec   = ((u >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        sr   = sv ? (sa - sb) : (sa + sb + longint'(cv));
        eo   = (sr >= half) || (sr < -half);
    endfunction

    function automatic logic [31:0] cur_s(input int w);
        return (w == 8) ? {24'd0, s8} : {28'd0, s4};
    endfunction
    function automatic logic cur_busy(input int w);
        return (w == 8) ? busy8 : busy4;
    endfunction
    function automatic logic cur_done(input int w);
        return (w == 8) ? done8 : done4;
    endfunction
    function automatic logic cur_cout(input int w);
        return (w == 8) ? cout8 : cout4;
    endfunction
    function automatic logic cur_ovf(input int w);
        return (w == 8) ? ovf8 : ovf4;
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic cv);
        if (w == 8) begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; cin8 = cv;
        end else begin
            start4 = st; a4 = av[3:0]; b4 = bv[3:0]; sub4 = sv; cin4 = cv;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation from IDLE or DONE and check handshake, hold and result
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv, input logic scramble, input string tag);
        logic [31:0] es, prev_s;
        logic ec, eo;
        int n;
        model(w, av, bv, sv, cv, es, ec, eo);
        prev_s = cur_s(w);
        drive(w, 1'b1, av, bv, sv, cv);
        tick();
        drive(w, 1'b0, av, bv, sv, cv);
        n = 0;
        while (cur_done(w) !== 1'b1 && n <= 3 * w) begin
            n_tests++;
            if (cur_busy(w) !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy step %0d: got %b expected 1", tag, n, cur_busy(w));
            end
            n_tests++;
            if (cur_s(w) !== prev_s) begin
                n_fail++;
                $display("FAIL %s s_hold step %0d: got %h expected %h", tag, n, cur_s(w), prev_s);
            end
            if (scramble)
                drive(w, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            n++;
        end
        drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_tests++;
        if (n !== w) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges expected %0d", tag, n, w);
        end
        n_tests++;
        if (cur_busy(w) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_in_done: got %b expected 0", tag, cur_busy(w));
        end
        n_tests++;
        if (cur_s(w) !== es || cur_cout(w) !== ec || cur_ovf(w) !== eo) begin
            n_fail++;
            $display("FAIL %s result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     tag, cur_s(w), cur_cout(w), cur_ovf(w), es, ec, eo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_tests++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                     busy8, done8, s8, cout8, ovf8);
        end
        n_tests++;
        if ({busy4, done4, s4, cout4, ovf4} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset4: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                     busy4, done4, s4, cout4, ovf4);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add8();
        run_op(8, 32'h3C, 32'h45, 1'b0, 1'b0, 1'b0, "add8");
        n_tests++;
        if (s8 !== 8'h81 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL add8_const: got s=%h cout=%b ovf=%b expected s=81 cout=0 ovf=1", s8, cout8, ovf8);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(8, 32'h05, 32'h07, 1'b1, 1'b0, 1'b0, "sub8");
        n_tests++;
        if (s8 !== 8'hFE || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sub8_const: got s=%h cout=%b ovf=%b expected s=fe cout=0 ovf=0", s8, cout8, ovf8);
        end
        run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, "b2b8");
        n_tests++;
        if (s8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b8_const: got s=%h cout=%b ovf=%b expected s=00 cout=1 ovf=0", s8, cout8, ovf8);
        end
        tick();
        n_tests++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", done8, busy8);
        end
    endtask

    task automatic test_width4();
        run_op(4, 32'h9, 32'h9, 1'b0, 1'b1, 1'b0, "add4");
        n_tests++;
        if (s4 !== 4'b0011 || cout4 !== 1'b1 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL add4_const: got s=%h cout=%b ovf=%b expected s=3 cout=1 ovf=1", s4, cout4, ovf4);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int dones, done_at;
        logic late_busy;
        logic [7:0] s_at_done;
        dones = 0; done_at = -1; late_busy = 1'b0; s_at_done = 8'd0;
        drive(8, 1'b1, 32'h10, 32'h01, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) drive(8, 1'b1, 32'hFF, 32'hFF, 1'b0, 1'b1);
            else        drive(8, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            if (dones > 0 && busy8 === 1'b1) late_busy = 1'b1;
            if (done8 === 1'b1) begin
                dones++;
                if (done_at < 0) begin
                    done_at = i;
                    s_at_done = s8;
                end
            end
        end
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_tests++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
        n_tests++;
        if (done_at !== 8) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 8", done_at);
        end
        n_tests++;
        if (s_at_done !== 8'h11) begin
            n_fail++;
            $display("FAIL ignore_result: got %h expected 11", s_at_done);
        end
        n_tests++;
        if (late_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_restart: got busy after done expected none");
        end
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        bad = 1'b0;
        drive(8, 1'b1, 32'h7F, 32'h01, 1'b0, 1'b0);
        tick();
        drive(8, 1'b0, 32'h7F, 32'h01, 1'b0, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'd0) begin
            n_fail++;
            $display("FAIL abort_clear: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
                     busy8, done8, s8, cout8, ovf8);
        end
        repeat (15) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity after abort expected idle");
        end
        run_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, "post_abort");
        n_tests++;
        if (s8 !== 8'h80 || ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_abort_const: got s=%h ovf=%b expected s=80 ovf=1", s8, ovf8);
        end
        tick();
    endtask

    task automatic test_reset_start_same_edge();
        reset = 1'b1;
        drive(8, 1'b1, 32'h12, 32'h34, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: got busy=%b done=%b expected 0 0", busy8, done8);
        end
        tick();
        n_tests++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins_idle: got busy=%b expected 0", busy8);
        end
    endtask

    task automatic test_random();
        int w, gap;
        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 2) == 0) ? 4 : 8;
            run_op(w, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), (w == 8) ? "rand8" : "rand4");
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) tick();
                n_tests++;
                if (done8 !== 1'b0 || done4 !== 1'b0 || busy8 !== 1'b0 || busy4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle: got done8=%b done4=%b busy8=%b busy4=%b expected 0",
                             done8, done4, busy8, busy4);
                end
            end
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add8();
        test_back_to_back();
        test_width4();
        test_start_ignored();
        test_reset_mid_run();
        test_reset_start_same_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
